plp_bus_arbiter: RTL and testbench

Two-master arbiter and sequencer for the PLP memory-mapped bus. Master 0 is the CPU data port; master 1 is a secondary bus master (VGA fetch or DMA). Exactly one transaction is forwarded at a time onto the shared bus that feeds the address decoder and its slave modules. The block provides round-robin fairness, alignment checking and a bus timeout that converts a hung slave into an error response.

---
 rtl/plp_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_plp_bus_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/plp_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the PLP bus.
// Checks alignment and converts a hung slave into an error response.
module plp_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TOUT_W  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [TOUT_W-1:0] TMAX =
    TOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic [TOUT_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rd0_q, rd0_d;
  logic [31:0]       rd1_q, rd1_d;

  logic              pick;
  logic [1:0]        pick_oh;
  logic [31:0]       sel_addr;
  logic              sel_we;
  logic [31:0]       sel_wdata;

  // Choose the next owner: a lone requester wins, a tie goes to the
  // master that was not served last.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      (m0_req && m1_req):  pick = ~last_q;
      (!m0_req && m1_req): pick = 1'b1;
      default:             pick = 1'b0;
    endcase
    pick_oh   = pick ? 2'b10 : 2'b01;
    sel_addr  = pick ? m1_addr : m0_addr;
    sel_we    = pick ? m1_we : m0_we;
    sel_wdata = pick ? m1_wdata : m0_wdata;
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    ack_d   = ack_q;
    err_d   = err_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d = pick_oh;
          last_d  = pick;
          busy_d  = 1'b1;
          if (sel_addr[1:0] == 2'b00) begin
            req_d   = 1'b1;
            addr_d  = sel_addr;
            we_d    = sel_we;
            wdata_d = sel_wdata;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            ack_d   = pick_oh;
            err_d   = pick_oh;
            if (pick) rd1_d = '0;
            else      rd0_d = '0;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          err_d   = 2'b00;
          if (grant_q[1]) rd1_d = bus_rdata;
          else            rd0_d = bus_rdata;
          state_d = DONE;
        end else if (TIMEOUT != 0 && cnt_q == TMAX) begin
          req_d   = 1'b0;
          ack_d   = grant_q;
          err_d   = grant_q;
          if (grant_q[1]) rd1_d = '0;
          else            rd0_d = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        ack_d   = 2'b00;
        err_d   = 2'b00;
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign bus_req   = req_q;
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;

endmodule

// File: tb/tb_plp_bus_arbiter.sv
// Directed bench for plp_bus_arbiter with TIMEOUT=4.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_plp_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  grant;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  plp_bus_arbiter #(.TIMEOUT(4), .TOUT_W(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0]  exp_g;
    logic [31:0] got_rd;

    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    bus_ack = 0; bus_rdata = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_bus_req", bus_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {m1_ack, m0_ack}, 0);
    chk("rst_errs", {m1_err, m0_err}, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);

    // Single read, slave acks two cycles after bus_req
    m0_req = 1; m0_addr = 32'h1000_0010; m0_we = 0;
    tick();
    chk("rd_bus_req", bus_req, 1);
    chk("rd_bus_addr", bus_addr, 32'h1000_0010);
    chk("rd_bus_we", bus_we, 0);
    chk("rd_grant", grant, 2'b01);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_hold", {bus_req, grant}, 3'b101);
    tick();
    bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    tick();
    bus_ack = 0;
    chk("rd_ack", m0_ack, 1);
    chk("rd_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("rd_err", m0_err, 0);
    chk("rd_m1_ack", m1_ack, 0);
    chk("rd_req_drop", bus_req, 0);
    chk("rd_grant_done", grant, 2'b01);
    m0_req = 0;
    tick();
    chk("rd_ack_pulse", m0_ack, 0);
    chk("rd_grant_idle", grant, 0);
    chk("rd_rdata_hold", m0_rdata, 32'hCAFE_F00D);
    chk("rd_idle_busy", busy, 0);

    // bus_ack in IDLE is ignored
    bus_ack = 1;
    tick();
    bus_ack = 0;
    chk("idle_ack_ign", {busy, m1_ack, m0_ack, bus_req}, 0);

    // Round robin under continuous contention
    do_reset();
    m0_req = 1; m0_addr = 32'h100; m0_we = 0;
    m1_req = 1; m1_addr = 32'h200; m1_we = 1; m1_wdata = 32'h77;
    for (int t = 0; t < 4; t++) begin
      exp_g = t[0] ? 2'b10 : 2'b01;
      n = 0;
      while (!bus_req && n < 8) begin
        tick();
        n++;
      end
      chk("rr_bus_req", bus_req, 1);
      chk("rr_grant", grant, exp_g);
      chk("rr_addr", bus_addr, t[0] ? 32'h200 : 32'h100);
      bus_ack = 1; bus_rdata = 32'h100 + t;
      tick();
      bus_ack = 0;
      chk("rr_req_once", bus_req, 0);
      chk("rr_ack_pair", {m1_ack, m0_ack}, exp_g);
      got_rd = exp_g[1] ? m1_rdata : m0_rdata;
      chk("rr_rdata", got_rd, 32'h100 + t);
      if (t == 3) begin
        m0_req = 0;
        m1_req = 0;
      end
    end
    tick();
    chk("rr_idle", {busy, grant}, 0);

    // Timeout: m1 write, slave never answers
    m1_req = 1; m1_addr = 32'hF020_0000; m1_we = 1;
    m1_wdata = 32'hDEAD_BEEF;
    tick();
    chk("to_addr", bus_addr, 32'hF020_0000);
    chk("to_we_data", {31'd0, bus_we} ^ bus_wdata, 32'hDEAD_BEEE);
    n = 0;
    while (bus_req && n < 10) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 4);
    chk("to_ack", m1_ack, 1);
    chk("to_err", m1_err, 1);
    chk("to_rdata", m1_rdata, 0);
    m1_req = 0;
    tick();
    chk("to_idle", {busy, grant, m1_ack, m1_err}, 0);

    // Ack and timeout in the same cycle: ack wins
    m0_req = 1; m0_addr = 32'h20; m0_we = 0;
    tick();
    tick();
    tick();
    tick();
    chk("col_req_c4", bus_req, 1);
    bus_ack = 1; bus_rdata = 32'h1234_5678;
    tick();
    bus_ack = 0;
    chk("col_ack", m0_ack, 1);
    chk("col_err", m0_err, 0);
    chk("col_rdata", m0_rdata, 32'h1234_5678);
    m0_req = 0;
    tick();

    // Misaligned access never reaches the bus
    m0_req = 1; m0_addr = 32'hF010_0002; m0_we = 0;
    n = 0;
    while (!m0_ack && n < 4) begin
      tick();
      chk("mis_no_bus", bus_req, 0);
      n++;
    end
    chk("mis_ack", m0_ack, 1);
    chk("mis_err", m0_err, 1);
    chk("mis_rdata", m0_rdata, 0);
    chk("mis_grant", grant, 2'b01);
    m0_req = 0;
    tick();
    chk("mis_clear", {m0_ack, m0_err, bus_req, busy}, 0);

    // Reset in the second BUSY cycle
    m0_req = 1; m0_addr = 32'h30;
    tick();
    tick();
    chk("rm_busy_c2", bus_req, 1);
    rst = 1;
    tick();
    rst = 0;
    m0_req = 0;
    chk("rm_req", bus_req, 0);
    chk("rm_grant", grant, 0);
    chk("rm_busy", busy, 0);
    chk("rm_no_ack", {m1_ack, m0_ack}, 0);
    tick();
    chk("rm_still_no_ack", {m1_ack, m0_ack}, 0);
    m1_req = 1; m1_addr = 32'h40; m1_we = 0;
    tick();
    chk("rm_m1_grant", grant, 2'b10);
    chk("rm_m1_req", bus_req, 1);
    bus_ack = 1; bus_rdata = 32'h0000_A5A5;
    tick();
    bus_ack = 0;
    chk("rm_m1_ack", m1_ack, 1);
    chk("rm_m1_rdata", m1_rdata, 32'h0000_A5A5);
    chk("rm_m1_err", m1_err, 0);
    m1_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
